// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds the SoC in reset until the clock source is locked and stable,
// then releases the peripheral reset first and the core reset STAGE_GAP cycles later.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  input  logic       soft_reset_req,
  output logic       reset_periph,
  output logic       reset,
  output logic       ready,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [7:0] COUNT_SAT  = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    HOLD       = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } state_t;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be at least 2");
  end

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            locked_s;
  logic            lock_loss, soft_evt;

  logic            reset_periph_d, reset_d, ready_d;
  logic [1:0]      reset_cause_d;
  logic [7:0]      reset_count_d;

  // Lock synchronizer; only its last stage feeds the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State, counter and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      reset_periph <= 1'b1;
      reset        <= 1'b1;
      ready        <= 1'b0;
      reset_cause  <= CAUSE_POR;
      reset_count  <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      reset_periph <= reset_periph_d;
      reset        <= reset_d;
      ready        <= ready_d;
      reset_cause  <= reset_cause_d;
      reset_count  <= reset_count_d;
    end
  end

  // Next-state and counter; lock loss outranks a coincident soft request.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    lock_loss = 1'b0;
    soft_evt  = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_d = REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      REL_PERIPH: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (soft_reset_req) begin
          soft_evt = 1'b1;
          state_d  = HOLD;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    if (lock_loss) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  // Output next-values decode from the next state so the registered outputs track the state exactly.
  always_comb begin
    reset_periph_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    reset_d        = (state_d != RUN);
    ready_d        = (state_d == RUN);
    reset_cause_d  = reset_cause;
    reset_count_d  = reset_count;
    if (lock_loss)     reset_cause_d = CAUSE_LOCK;
    else if (soft_evt) reset_cause_d = CAUSE_SOFT;
    if ((lock_loss || soft_evt) && (reset_count != COUNT_SAT)) begin
      reset_count_d = reset_count + 8'd1;
    end
  end

endmodule
